// File: rtl/blur_controller.sv
// rtl/blur_controller.sv - 3x3 window fetch and write-back sequencer for a BRAM-backed image blur
// Define BLUR_CTRL_ZERO_PAD_EN to capture 0 for out-of-image window slots instead of clamped edge pixels.
module blur_controller #(
    parameter int WIDTH  = 8,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    output logic                 busy_out,
    output logic                 done_out,
    output logic [ADDR_W-1:0]    rd_addr_out,
    input  logic [WIDTH-1:0]     rd_data_in,
    output logic [3*WIDTH-1:0]   r0_data_out,
    output logic [3*WIDTH-1:0]   r1_data_out,
    output logic [3*WIDTH-1:0]   r2_data_out,
    output logic                 gauss_valid_out,
    input  logic [WIDTH-1:0]     gauss_data_in,
    input  logic                 gauss_valid_in,
    output logic [ADDR_W-1:0]    wr_addr_out,
    output logic [WIDTH-1:0]     wr_data_out,
    output logic                 wr_en_out
);
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [ADDR_W:0] TOTAL_CNT = (ADDR_W + 1)'(IMG_W * IMG_H);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, DRAIN} state_t;

    state_t            state;
    logic [XW-1:0]     px, nx;
    logic [YW-1:0]     py, ny;
    logic [3:0]        tap;
    logic              wait_cnt;
    logic [ADDR_W:0]   wr_cnt;
    logic              v_d1, v_d2;
    logic [3:0]        tap_d1, tap_d2;
    logic [WIDTH-1:0]  win [9];
    logic [WIDTH-1:0]  win_next [9];
    logic [WIDTH-1:0]  cap_data;
    logic [ADDR_W-1:0] nxt_addr;
    logic              last_px;
    logic              wr_accept;
    int                bx, by, tt, ux, uy, cx, cy;
`ifdef BLUR_CTRL_ZERO_PAD_EN
    logic              nxt_oob, oob_cur, oob_d1, oob_d2;
`endif

    // Address of the next tap to issue: (0,0) on start, next tap mid-fetch, or tap 0 of the next pixel.
    always_comb begin
        last_px = (px == XW'(IMG_W - 1)) && (py == YW'(IMG_H - 1));
        if (px == XW'(IMG_W - 1)) begin
            nx = '0;
            ny = py + YW'(1);
        end else begin
            nx = px + XW'(1);
            ny = py;
        end
        case (state)
            IDLE:    begin bx = 0;         by = 0;         tt = 0;            end
            FETCH:   begin bx = int'(px);  by = int'(py);  tt = int'(tap) + 1; end
            default: begin bx = int'(nx);  by = int'(ny);  tt = 0;            end
        endcase
        ux = bx + (tt % 3) - 1;
        uy = by + (tt / 3) - 1;
        cx = (ux < 0) ? 0 : ((ux > IMG_W - 1) ? IMG_W - 1 : ux);
        cy = (uy < 0) ? 0 : ((uy > IMG_H - 1) ? IMG_H - 1 : uy);
        nxt_addr = ADDR_W'(cy * IMG_W + cx);
`ifdef BLUR_CTRL_ZERO_PAD_EN
        nxt_oob = (ux != cx) || (uy != cy);
`endif
    end

`ifdef BLUR_CTRL_ZERO_PAD_EN
    assign cap_data = oob_d2 ? '0 : rd_data_in;
`else
    assign cap_data = rd_data_in;
`endif

    always_comb begin
        for (int i = 0; i < 9; i++) win_next[i] = win[i];
        if (v_d2) win_next[tap_d2] = cap_data;
    end

    // Writes bypass the FSM so results landing during a later fetch are never lost.
    assign wr_accept   = gauss_valid_in && (state != IDLE) && !rst_in;
    assign wr_en_out   = wr_accept;
    assign wr_data_out = wr_accept ? gauss_data_in : '0;
    assign wr_addr_out = rst_in ? '0 : wr_cnt[ADDR_W-1:0];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= IDLE;
            px              <= '0;
            py              <= '0;
            tap             <= '0;
            wait_cnt        <= 1'b0;
            wr_cnt          <= '0;
            v_d1            <= 1'b0;
            v_d2            <= 1'b0;
            tap_d1          <= '0;
            tap_d2          <= '0;
            busy_out        <= 1'b0;
            done_out        <= 1'b0;
            gauss_valid_out <= 1'b0;
            rd_addr_out     <= '0;
            r0_data_out     <= '0;
            r1_data_out     <= '0;
            r2_data_out     <= '0;
            for (int i = 0; i < 9; i++) win[i] <= '0;
`ifdef BLUR_CTRL_ZERO_PAD_EN
            oob_cur         <= 1'b0;
            oob_d1          <= 1'b0;
            oob_d2          <= 1'b0;
`endif
        end else begin
            done_out        <= 1'b0;
            gauss_valid_out <= 1'b0;
            v_d1            <= (state == FETCH);
            tap_d1          <= tap;
            v_d2            <= v_d1;
            tap_d2          <= tap_d1;
`ifdef BLUR_CTRL_ZERO_PAD_EN
            oob_d1          <= oob_cur;
            oob_d2          <= oob_d1;
`endif
            for (int i = 0; i < 9; i++) win[i] <= win_next[i];
            if (wr_accept) wr_cnt <= wr_cnt + 1'b1;
            if (done_out) busy_out <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_in) begin
                        state       <= FETCH;
                        busy_out    <= 1'b1;
                        px          <= '0;
                        py          <= '0;
                        tap         <= '0;
                        wr_cnt      <= '0;
                        rd_addr_out <= nxt_addr;
`ifdef BLUR_CTRL_ZERO_PAD_EN
                        oob_cur     <= nxt_oob;
`endif
                    end
                end
                FETCH: begin
                    if (tap == 4'd8) begin
                        state    <= WAIT;
                        wait_cnt <= 1'b0;
                    end else begin
                        tap         <= tap + 4'd1;
                        rd_addr_out <= nxt_addr;
`ifdef BLUR_CTRL_ZERO_PAD_EN
                        oob_cur     <= nxt_oob;
`endif
                    end
                end
                WAIT: begin
                    if (wait_cnt) begin
                        // Last tap lands on this edge, so rows are built from win_next.
                        state           <= EMIT;
                        gauss_valid_out <= 1'b1;
                        r0_data_out     <= {win_next[0], win_next[1], win_next[2]};
                        r1_data_out     <= {win_next[3], win_next[4], win_next[5]};
                        r2_data_out     <= {win_next[6], win_next[7], win_next[8]};
                    end else begin
                        wait_cnt <= 1'b1;
                    end
                end
                EMIT: begin
                    if (last_px) begin
                        state <= DRAIN;
                    end else begin
                        state       <= FETCH;
                        px          <= nx;
                        py          <= ny;
                        tap         <= '0;
                        rd_addr_out <= nxt_addr;
`ifdef BLUR_CTRL_ZERO_PAD_EN
                        oob_cur     <= nxt_oob;
`endif
                    end
                end
                DRAIN: begin
                    if (wr_cnt == TOTAL_CNT) begin
                        done_out <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_blur_controller.sv
// tb/tb_blur_controller.sv - directed bench for blur_controller on a 4x4 image with BRAM and blur datapath models
module tb_blur_controller;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        start_in;
    logic        busy_out, done_out;
    logic [3:0]  rd_addr_out;
    logic [7:0]  rd_data_in;
    logic [23:0] r0_data_out, r1_data_out, r2_data_out;
    logic        gauss_valid_out;
    logic [7:0]  gauss_data_in;
    logic        gauss_valid_in;
    logic [3:0]  wr_addr_out;
    logic [7:0]  wr_data_out;
    logic        wr_en_out;

    blur_controller #(.WIDTH(8), .IMG_W(4), .IMG_H(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
        .busy_out(busy_out), .done_out(done_out),
        .rd_addr_out(rd_addr_out), .rd_data_in(rd_data_in),
        .r0_data_out(r0_data_out), .r1_data_out(r1_data_out), .r2_data_out(r2_data_out),
        .gauss_valid_out(gauss_valid_out), .gauss_data_in(gauss_data_in),
        .gauss_valid_in(gauss_valid_in), .wr_addr_out(wr_addr_out),
        .wr_data_out(wr_data_out), .wr_en_out(wr_en_out)
    );

    always #5 clk_in = ~clk_in;

    int          checks, errors;
    int          cyc, n_wr, n_done, n_emit, gap_bad, seq_bad, last_emit_cyc;
    logic [7:0]  mem [16];
    logic [7:0]  out_img [16];
    logic [23:0] em_r0 [16], em_r1 [16], em_r2 [16];
    logic [7:0]  d1, d2;
    logic        pv [4];
    logic [7:0]  pd [4];
    int          taps00 [9] = '{0, 0, 1, 0, 0, 1, 4, 4, 5};

    function automatic logic [7:0] blur(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
        int s;
        s = int'(a[23:16]) + 2 * int'(a[15:8]) + int'(a[7:0])
          + 2 * int'(b[23:16]) + 4 * int'(b[15:8]) + 2 * int'(b[7:0])
          + int'(c[23:16]) + 2 * int'(c[15:8]) + int'(c[7:0]);
        return 8'(s >> 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // BRAM with 2-cycle read latency, 4-stage blur datapath, and write/strobe monitor.
    initial begin
        cyc = 0; n_wr = 0; n_done = 0; n_emit = 0; gap_bad = 0; seq_bad = 0; last_emit_cyc = -1;
        d1 = '0; d2 = '0;
        for (int i = 0; i < 4; i++) begin pv[i] = 1'b0; pd[i] = '0; end
        rd_data_in = '0; gauss_valid_in = 1'b0; gauss_data_in = '0;
        forever begin
            @(posedge clk_in); #1;
            cyc++;
            rd_data_in = d2;
            d2 = d1;
            d1 = mem[rd_addr_out];
            for (int i = 3; i > 0; i--) begin pv[i] = pv[i-1]; pd[i] = pd[i-1]; end
            pv[0] = gauss_valid_out;
            pd[0] = blur(r0_data_out, r1_data_out, r2_data_out);
            gauss_valid_in = pv[3];
            gauss_data_in  = pd[3];
            if (gauss_valid_out) begin
                if (last_emit_cyc >= 0 && cyc - last_emit_cyc != 12) gap_bad++;
                last_emit_cyc = cyc;
                if (n_emit < 16) begin
                    em_r0[n_emit] = r0_data_out;
                    em_r1[n_emit] = r1_data_out;
                    em_r2[n_emit] = r2_data_out;
                end
                n_emit++;
            end
            if (done_out) n_done++;
            @(negedge clk_in);
            if (wr_en_out) begin
                if (int'(wr_addr_out) != n_wr) seq_bad++;
                out_img[wr_addr_out] = wr_data_out;
                n_wr++;
            end
        end
    end

    task automatic run_image(input string nm, input int mid_start_at);
        bit got_done;
        n_wr = 0; n_done = 0; n_emit = 0; gap_bad = 0; seq_bad = 0; last_emit_cyc = -1;
        for (int i = 0; i < 16; i++) out_img[i] = 8'hxx;
        @(negedge clk_in); start_in = 1'b1;
        @(negedge clk_in); start_in = 1'b0;
        chk({nm, "_busy_after_start"}, busy_out, 1);
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("%s_rd_addr_tap%0d", nm, k), rd_addr_out, taps00[k]);
            @(negedge clk_in);
        end
        got_done = 1'b0;
        for (int c = 0; c < 400 && !got_done; c++) begin
            start_in = (c == mid_start_at);
            if (done_out) begin
                got_done = 1'b1;
                chk({nm, "_busy_during_done"}, busy_out, 1);
            end else begin
                @(negedge clk_in);
            end
        end
        start_in = 1'b0;
        chk({nm, "_done_seen"}, got_done, 1);
        repeat (20) @(negedge clk_in);
        chk({nm, "_done_count"}, n_done, 1);
        chk({nm, "_write_count"}, n_wr, 16);
        chk({nm, "_emit_count"}, n_emit, 16);
        chk({nm, "_emit_spacing_bad"}, gap_bad, 0);
        chk({nm, "_write_order_bad"}, seq_bad, 0);
        chk({nm, "_busy_after_done"}, busy_out, 0);
    endtask

    initial begin
        int exp_v;
        bit found;
        checks = 0; errors = 0;
        start_in = 1'b0; rst_in = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (3) @(negedge clk_in);
        chk("rst_busy", busy_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_gauss_valid", gauss_valid_out, 0);
        chk("rst_wr_en", wr_en_out, 0);
        chk("rst_rd_addr", rd_addr_out, 0);
        chk("rst_wr_addr", wr_addr_out, 0);
        chk("rst_wr_data", wr_data_out, 0);
        chk("rst_r0", r0_data_out, 0);
        chk("rst_r1", r1_data_out, 0);
        chk("rst_r2", r2_data_out, 0);
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);

        // Flat image; a stray start pulse mid-run must be ignored.
        for (int i = 0; i < 16; i++) mem[i] = 8'd16;
        run_image("flat", 60);
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
`ifdef BLUR_CTRL_ZERO_PAD_EN
                if ((x == 0 || x == 3) && (y == 0 || y == 3)) exp_v = 9;
                else if (x == 0 || x == 3 || y == 0 || y == 3) exp_v = 12;
                else exp_v = 16;
`else
                exp_v = 16;
`endif
                chk($sformatf("flat_out_x%0d_y%0d", x, y), out_img[y*4+x], exp_v);
            end
        end

        // Impulse of 160 at (1,1).
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[5] = 8'd160;
        run_image("impulse", -1);
        chk("imp_out_1_1", out_img[5], 40);
        chk("imp_out_0_1", out_img[4], 20);
        chk("imp_out_1_0", out_img[1], 20);
        chk("imp_out_0_0", out_img[0], 10);
        chk("imp_out_3_3", out_img[15], 0);
        chk("imp_px0_r2", em_r2[0], 24'h0000A0);
        chk("imp_px2_r2", em_r2[2], 24'hA00000);
        chk("imp_px5_r0", em_r0[5], 24'h000000);
        chk("imp_px5_r1", em_r1[5], 24'h00A000);

        // Abort mid-FETCH of pixel 5, then a clean run.
        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 10);
        n_emit = 0; n_done = 0; last_emit_cyc = -1;
        @(negedge clk_in); start_in = 1'b1;
        @(negedge clk_in); start_in = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (n_emit >= 5) found = 1'b1;
            else @(negedge clk_in);
        end
        chk("abort_reached_px5", found, 1);
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("abort_rst_busy", busy_out, 0);
        chk("abort_rst_gauss_valid", gauss_valid_out, 0);
        chk("abort_rst_rd_addr", rd_addr_out, 0);
        chk("abort_rst_r1", r1_data_out, 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        n_wr = 0; n_done = 0;
        repeat (40) @(negedge clk_in);
        chk("abort_no_done", n_done, 0);
        chk("abort_no_writes", n_wr, 0);
        chk("abort_idle_busy", busy_out, 0);
        run_image("rerun", -1);
        chk("rerun_out_0", out_img[0], blur({mem[0], mem[0], mem[1]}, {mem[0], mem[0], mem[1]},
                                             {mem[4], mem[4], mem[5]}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
